dmem_arbiter: RTL and testbench

Two-requester arbiter and access sequencer for the single-port data memory. It shares the port between the CPU load/store path (after MemOrIO address decode) and a program/data loader (UART bootloader or debug port). Each access is a req/ack transaction with a parameterised synchronous read latency. The CPU stalls while cpu_req is high and cpu_ack is low.

---
 rtl/dmem_arbiter_pkg.sv | 11 +
 rtl/dmem_arbiter_rr_arb2.sv | 16 +
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, requester port IDs
// and default sizes.
package dmem_arbiter_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LD  = 1'b1;

    localparam int DEF_ADDR_WIDTH = 14;
    localparam int DEF_DATA_WIDTH = 32;
endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the port that
// was not served last.
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       rr_last,
    output logic [1:0] gnt
);
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (rr_last == PORT_LD) ? 2'b01 : 2'b10;
        end
    end
endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and the
// loader; one req/ack transaction at a time with a fixed read latency.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int READ_LAT   = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [31:0]           cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_ack,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [31:0]           ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic                  ld_ack,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  addr_err
);
    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  rr_last_q, rr_last_d;
    logic                  we_q, we_d;
    logic [29:0]           addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [2:0]            wait_cnt_q, wait_cnt_d;
    logic [DATA_WIDTH-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_WIDTH-1:0] ld_rdata_q, ld_rdata_d;
    logic                  cpu_ack_q, cpu_ack_d;
    logic                  ld_ack_q, ld_ack_d;
    logic                  mem_we_q, mem_we_d;
    logic [1:0]            grant_q, grant_d;
    logic                  busy_q, busy_d;
    logic                  addr_err_q, addr_err_d;
    logic [1:0]            gnt;
    logic                  in_range_q, in_range_d;
    logic                  unused_byte_offs;

    // Byte offsets are meaningless for a word-wide memory.
    assign unused_byte_offs = ^{cpu_addr[1:0], ld_addr[1:0]};

    rr_arb2 u_pick (
        .req     ({ld_req, cpu_req}),
        .rr_last (rr_last_q),
        .gnt     (gnt)
    );

    assign in_range_q = (addr_q[29:ADDR_WIDTH] == '0);
    assign in_range_d = (addr_d[29:ADDR_WIDTH] == '0);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_last_d   = rr_last_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        ld_rdata_d  = ld_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    owner_d   = gnt[1];
                    rr_last_d = gnt[1];
                    we_d      = gnt[1] ? ld_we : cpu_we;
                    addr_d    = gnt[1] ? ld_addr[31:2] : cpu_addr[31:2];
                    wdata_d   = gnt[1] ? ld_wdata : cpu_wdata;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                wait_cnt_d = 3'(READ_LAT);
                state_d    = we_q ? DONE : WAIT;
            end
            WAIT: begin
                wait_cnt_d = wait_cnt_q - 3'd1;
                if (wait_cnt_q == 3'd1) begin
                    if (owner_q == PORT_LD) ld_rdata_d  = in_range_q ? mem_rdata : '0;
                    else                    cpu_rdata_d = in_range_q ? mem_rdata : '0;
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they appear registered with the state.
    always_comb begin
        busy_d     = (state_d != IDLE);
        grant_d    = busy_d ? (owner_d ? 2'b10 : 2'b01) : 2'b00;
        mem_we_d   = (state_d == ISSUE) && we_d && in_range_d;
        cpu_ack_d  = (state_d == DONE) && (owner_d == PORT_CPU);
        ld_ack_d   = (state_d == DONE) && (owner_d == PORT_LD);
        addr_err_d = (state_d == DONE) && !in_range_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= PORT_CPU;
            rr_last_q   <= PORT_LD;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_cnt_q  <= '0;
            cpu_rdata_q <= '0;
            ld_rdata_q  <= '0;
            cpu_ack_q   <= 1'b0;
            ld_ack_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            grant_q     <= 2'b00;
            busy_q      <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_last_q   <= rr_last_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            ld_rdata_q  <= ld_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            ld_ack_q    <= ld_ack_d;
            mem_we_q    <= mem_we_d;
            grant_q     <= grant_d;
            busy_q      <= busy_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign cpu_rdata = cpu_rdata_q;
    assign ld_rdata  = ld_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign ld_ack    = ld_ack_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q[ADDR_WIDTH-1:0];
    assign mem_wdata = wdata_q;
    assign grant     = grant_q;
    assign busy      = busy_q;
    assign addr_err  = addr_err_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (READ_LAT 1 and 3), a transaction-level
// model checked every cycle, and directed scenarios with literal expectations.
module tb_dmem_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic          rst   [2];
    logic          req   [2][2];
    logic          we    [2][2];
    logic [31:0]   addr  [2][2];
    logic [DW-1:0] wdata [2][2];
    logic [DW-1:0] mrd   [2];
    logic [DW-1:0] rdata [2][2];
    logic          ack   [2][2];
    logic          mwe   [2];
    logic [AW-1:0] maddr [2];
    logic [DW-1:0] mwd   [2];
    logic [1:0]    gr    [2];
    logic          bsy   [2];
    logic          aerr  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(g == 0 ? 1 : 3)) u_dut (
            .clock     (clock),
            .reset     (rst[g]),
            .cpu_req   (req[g][0]),
            .cpu_we    (we[g][0]),
            .cpu_addr  (addr[g][0]),
            .cpu_wdata (wdata[g][0]),
            .cpu_rdata (rdata[g][0]),
            .cpu_ack   (ack[g][0]),
            .ld_req    (req[g][1]),
            .ld_we     (we[g][1]),
            .ld_addr   (addr[g][1]),
            .ld_wdata  (wdata[g][1]),
            .ld_rdata  (rdata[g][1]),
            .ld_ack    (ack[g][1]),
            .mem_we    (mwe[g]),
            .mem_addr  (maddr[g]),
            .mem_wdata (mwd[g]),
            .mem_rdata (mrd[g]),
            .grant     (gr[g]),
            .busy      (bsy[g]),
            .addr_err  (aerr[g])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit inr(input logic [31:0] a);
        return a[31:AW+2] == '0;
    endfunction

    // Transaction model: an access accepted at cycle s occupies s+1..e, where
    // e = s+2 for writes and s+2+latency for reads; ack/addr_err land on e.
    bit            m_act  [2] = '{0, 0};
    int            m_start[2] = '{0, 0};
    int            m_end  [2] = '{0, 0};
    int            m_own  [2] = '{0, 0};
    bit            m_we   [2] = '{0, 0};
    logic [31:0]   m_addr [2] = '{0, 0};
    logic [DW-1:0] m_wd   [2] = '{0, 0};
    int            m_rr   [2] = '{1, 1};
    logic [DW-1:0] m_rd   [2][2] = '{'{0, 0}, '{0, 0}};
    bit            mon_en = 0;

    int            we_cnt  [2] = '{0, 0};
    int            we_cyc  [2] = '{0, 0};
    logic [AW-1:0] we_addr [2] = '{0, 0};
    logic [DW-1:0] we_data [2] = '{0, 0};
    int            ack_cnt [2][2] = '{'{0, 0}, '{0, 0}};
    int            err_cyc [2] = '{-1, -1};
    int            both_ack[2] = '{0, 0};

    int mon_w, lat_v;
    bit act_v;

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            lat_v = (i == 0) ? 1 : 3;
            act_v = m_act[i] && cyc > m_start[i] && cyc <= m_end[i];
            if (mon_en) begin
                chk($sformatf("u%0d busy", i), bsy[i], act_v);
                chk($sformatf("u%0d grant", i), gr[i], act_v ? (m_own[i] == 0 ? 2'b01 : 2'b10) : 2'b00);
                chk($sformatf("u%0d mem_we", i), mwe[i],
                    act_v && cyc == m_start[i] + 1 && m_we[i] && inr(m_addr[i]));
                chk($sformatf("u%0d cpu_ack", i), ack[i][0], act_v && cyc == m_end[i] && m_own[i] == 0);
                chk($sformatf("u%0d ld_ack", i), ack[i][1], act_v && cyc == m_end[i] && m_own[i] == 1);
                chk($sformatf("u%0d addr_err", i), aerr[i], act_v && cyc == m_end[i] && !inr(m_addr[i]));
                chk($sformatf("u%0d cpu_rdata", i), rdata[i][0], m_rd[i][0]);
                chk($sformatf("u%0d ld_rdata", i), rdata[i][1], m_rd[i][1]);
                if (act_v && cyc < m_end[i])
                    chk($sformatf("u%0d mem_addr", i), maddr[i], m_addr[i][AW+1:2]);
                if (act_v && cyc == m_start[i] + 1)
                    chk($sformatf("u%0d mem_wdata", i), mwd[i], m_wd[i]);
                if (mwe[i] === 1'b1) begin
                    we_cnt[i]++;
                    we_cyc[i]  = cyc;
                    we_addr[i] = maddr[i];
                    we_data[i] = mwd[i];
                end
                if (ack[i][0] === 1'b1) ack_cnt[i][0]++;
                if (ack[i][1] === 1'b1) ack_cnt[i][1]++;
                if (ack[i][0] === 1'b1 && ack[i][1] === 1'b1) both_ack[i]++;
                if (aerr[i] === 1'b1) err_cyc[i] = cyc;
            end
            if (rst[i]) begin
                m_act[i]   = 0;
                m_rr[i]    = 1;
                m_rd[i][0] = '0;
                m_rd[i][1] = '0;
            end else if (!m_act[i] || cyc > m_end[i]) begin
                if (req[i][0] || req[i][1]) begin
                    if (req[i][0] && req[i][1]) mon_w = 1 - m_rr[i];
                    else                        mon_w = req[i][1] ? 1 : 0;
                    m_act[i]   = 1;
                    m_start[i] = cyc;
                    m_own[i]   = mon_w;
                    m_we[i]    = we[i][mon_w];
                    m_addr[i]  = addr[i][mon_w];
                    m_wd[i]    = wdata[i][mon_w];
                    m_end[i]   = cyc + 2 + (we[i][mon_w] ? 0 : lat_v);
                    m_rr[i]    = mon_w;
                end
            end else if (!m_we[i] && cyc == m_end[i] - 1) begin
                m_rd[i][m_own[i]] = inr(m_addr[i]) ? mrd[i] : '0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        rst[0] = 1'b1;
        rst[1] = 1'b1;
        step();
        step();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        mon_en = 1;
    endtask

    // One access on instance i, port p; mem_rdata switches from rd_a to rd_b at
    // offset chg from the request cycle. Returns the request and ack cycles.
    task automatic access(input int i, input int p, input bit w, input logic [31:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] rd_a,
                          input logic [DW-1:0] rd_b, input int chg,
                          output int n, output int ack_at);
        req[i][p]   = 1'b1;
        we[i][p]    = w;
        addr[i][p]  = a;
        wdata[i][p] = d;
        mrd[i]      = rd_a;
        n      = cyc;
        ack_at = -1;
        for (int k = 0; k < 20 && ack_at < 0; k++) begin
            step();
            if (cyc - n >= chg) mrd[i] = rd_b;
            if (ack[i][p] === 1'b1) begin
                ack_at    = cyc;
                req[i][p] = 1'b0;
            end
        end
        req[i][p] = 1'b0;
        chk("ack seen within budget", ack_at >= 0, 1'b1);
        step();
    endtask

    int n, a, we0, both0, ack0;
    int order[$];

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i] = 1'b1;
            mrd[i] = '0;
            for (int p = 0; p < 2; p++) begin
                req[i][p]   = 1'b0;
                we[i][p]    = 1'b0;
                addr[i][p]  = '0;
                wdata[i][p] = '0;
            end
        end
        do_reset();
        for (int i = 0; i < 2; i++) begin
            chk("reset busy", bsy[i], 1'b0);
            chk("reset grant", gr[i], 2'b00);
            chk("reset cpu_rdata", rdata[i][0], '0);
        end

        // 1: CPU write
        we0 = we_cnt[0];
        access(0, 0, 1'b1, 32'h0000_0010, 32'hDEADBEEF, '0, '0, 99, n, a);
        chk("t1 ack latency", a - n, 2);
        chk("t1 mem_we count", we_cnt[0] - we0, 1);
        chk("t1 mem_we cycle", we_cyc[0] - n, 1);
        chk("t1 mem_addr", we_addr[0], 4);
        chk("t1 mem_wdata", we_data[0], 32'hDEADBEEF);

        // 2: CPU read back, latency 1
        we0 = we_cnt[0];
        access(0, 0, 1'b0, 32'h0000_0010, '0, 32'hDEADBEEF, 32'hDEADBEEF, 0, n, a);
        chk("t2 ack latency", a - n, 3);
        chk("t2 cpu_rdata", rdata[0][0], 32'hDEADBEEF);
        chk("t2 ld_rdata held", rdata[0][1], '0);
        chk("t2 no mem_we", we_cnt[0] - we0, 0);

        // 3: continuous dual requests right after reset
        do_reset();
        order.delete();
        both0 = both_ack[0];
        for (int p = 0; p < 2; p++) begin
            req[0][p]   = 1'b1;
            we[0][p]    = 1'b1;
            addr[0][p]  = (p == 0) ? 32'h100 : 32'h104;
            wdata[0][p] = (p == 0) ? 32'hC0C0_0000 : 32'h1D1D_0000;
        end
        for (int k = 0; k < 40 && order.size() < 4; k++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (ack[0][p] === 1'b1) begin
                    order.push_back(p);
                    req[0][p] = 1'b0;
                end else if (!req[0][p]) begin
                    req[0][p] = 1'b1;
                end
            end
        end
        req[0][0] = 1'b0;
        req[0][1] = 1'b0;
        step();
        chk("t3 grant count", order.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("t3 grant order %0d", k), (order.size() > k) ? order[k] : -1, k % 2);
        chk("t3 no double ack", both_ack[0] - both0, 0);

        // 4: loader in-range read, then out-of-range write and read
        access(0, 1, 1'b0, 32'h0000_0040, '0, 32'h5A5A5A5A, 32'h5A5A5A5A, 0, n, a);
        chk("t4 ld_rdata in range", rdata[0][1], 32'h5A5A5A5A);
        we0 = we_cnt[0];
        access(0, 1, 1'b1, 32'h0001_0000, 32'h12345678, '0, '0, 99, n, a);
        chk("t4 oor write ack latency", a - n, 2);
        chk("t4 oor write addr_err cycle", err_cyc[0], a);
        chk("t4 oor write no mem_we", we_cnt[0] - we0, 0);
        access(0, 1, 1'b0, 32'h0001_0000, '0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, n, a);
        chk("t4 oor read ack latency", a - n, 3);
        chk("t4 oor read addr_err cycle", err_cyc[0], a);
        chk("t4 oor read ld_rdata", rdata[0][1], '0);

        // 5: reset during WAIT of a CPU read
        access(0, 0, 1'b0, 32'h0000_0010, '0, 32'hDEADBEEF, 32'hDEADBEEF, 0, n, a);
        ack0 = ack_cnt[0][0];
        req[0][0] = 1'b1;
        we[0][0]  = 1'b0;
        mrd[0]    = 32'hABCD0123;
        step();
        step();
        rst[0] = 1'b1;
        step();
        rst[0]    = 1'b0;
        req[0][0] = 1'b0;
        chk("t5 busy", bsy[0], 1'b0);
        chk("t5 grant", gr[0], 2'b00);
        chk("t5 mem_we", mwe[0], 1'b0);
        chk("t5 cpu_rdata", rdata[0][0], '0);
        step();
        step();
        step();
        chk("t5 no cpu_ack", ack_cnt[0][0] - ack0, 0);

        // 6: latency-3 instance
        access(1, 0, 1'b1, 32'h0000_0008, 32'h0BADF00D, '0, '0, 99, n, a);
        chk("t6 write ack latency", a - n, 2);
        access(1, 1, 1'b0, 32'h0000_0020, '0, 32'h11111111, 32'h22222222, 4, n, a);
        chk("t6 read ack latency", a - n, 5);
        chk("t6 ld_rdata sample", rdata[1][1], 32'h22222222);
        mrd[1] = 32'h33333333;
        step();
        step();
        chk("t6 ld_rdata holds", rdata[1][1], 32'h22222222);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
